// File: rtl/maze_pkg.sv
// Shared definitions for the wall-following maze solver: heading codes,
// FSM state encoding and the heading rotation lookups.
package maze_pkg;

  localparam logic [11:0] HDNG_N = 12'h000;
  localparam logic [11:0] HDNG_W = 12'h3FF;
  localparam logic [11:0] HDNG_S = 12'h7FF;
  localparam logic [11:0] HDNG_E = 12'hC00;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MV        = 3'd1,
    ST_MV_WAIT   = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_DECIDE    = 3'd4,
    ST_HDNG_WAIT = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  // Headings are only ever one of the four canonical codes, so rotation is a table.
  function automatic logic [11:0] turn_left(input logic [11:0] hdng);
    logic [11:0] res;
    case (hdng)
      HDNG_N:  res = HDNG_W;
      HDNG_W:  res = HDNG_S;
      HDNG_S:  res = HDNG_E;
      HDNG_E:  res = HDNG_N;
      default: res = HDNG_N;
    endcase
    return res;
  endfunction

  function automatic logic [11:0] turn_right(input logic [11:0] hdng);
    logic [11:0] res;
    case (hdng)
      HDNG_N:  res = HDNG_E;
      HDNG_E:  res = HDNG_S;
      HDNG_S:  res = HDNG_W;
      HDNG_W:  res = HDNG_N;
      default: res = HDNG_N;
    endcase
    return res;
  endfunction

  function automatic logic [11:0] turn_rev(input logic [11:0] hdng);
    logic [11:0] res;
    case (hdng)
      HDNG_N:  res = HDNG_S;
      HDNG_S:  res = HDNG_N;
      HDNG_E:  res = HDNG_W;
      HDNG_W:  res = HDNG_E;
      default: res = HDNG_N;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/maze_solve.sv
// Wall-following command sequencer: issues one heading change or forward move
// to navigate at a time and waits for mv_cmplt before deciding the next step.
module maze_solve
  import maze_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_md,
  input  logic        cmd0,
  input  logic        lft_opn,
  input  logic        rght_opn,
  input  logic        frwrd_opn,
  input  logic        mv_cmplt,
  input  logic        sol_cmplt,
  output logic        strt_hdng,
  output logic        strt_mv,
  output logic        stp_lft,
  output logic        stp_rght,
  output logic [11:0] dsrd_hdng,
  output logic        solved
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  // Turn handshake: pulse strt_hdng one cycle after dsrd_hdng changes, then
  // ignore mv_cmplt until the cycle after the pulse.
  localparam logic [3:0] HDNG_LOAD   = 4'd2;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        aff_r;
  logic        aff_nxt_s;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_nxt_s;
  logic [11:0] dsrd_hdng_r;
  logic [11:0] dsrd_hdng_nxt_s;
  logic        strt_hdng_r;
  logic        strt_hdng_nxt_s;
  logic        strt_mv_r;
  logic        strt_mv_nxt_s;
  logic        stp_lft_r;
  logic        stp_lft_nxt_s;
  logic        stp_rght_r;
  logic        stp_rght_nxt_s;
  logic        solved_r;
  logic        solved_nxt_s;

  logic        aff_open_s;
  logic        opp_open_s;
  logic [11:0] toward_hdng_s;
  logic [11:0] away_hdng_s;

  assign aff_open_s    = aff_r ? lft_opn : rght_opn;
  assign opp_open_s    = aff_r ? rght_opn : lft_opn;
  assign toward_hdng_s = aff_r ? turn_left(dsrd_hdng_r) : turn_right(dsrd_hdng_r);
  assign away_hdng_s   = aff_r ? turn_right(dsrd_hdng_r) : turn_left(dsrd_hdng_r);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; dropping cmd_md overrides every other event.
  always_comb begin
    state_nxt_s = state_r;
    if (!cmd_md) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_nxt_s = ST_MV;
        ST_MV:   state_nxt_s = ST_MV_WAIT;
        ST_MV_WAIT: begin
          if (mv_cmplt) begin
            state_nxt_s = ST_SETTLE;
          end else begin
            state_nxt_s = ST_MV_WAIT;
          end
        end
        ST_SETTLE: begin
          if (cnt_r == 4'd0) begin
            state_nxt_s = ST_DECIDE;
          end else begin
            state_nxt_s = ST_SETTLE;
          end
        end
        ST_DECIDE: begin
          if (sol_cmplt) begin
            state_nxt_s = ST_DONE;
          end else if (aff_open_s) begin
            state_nxt_s = ST_HDNG_WAIT;
          end else if (frwrd_opn) begin
            state_nxt_s = ST_MV;
          end else begin
            state_nxt_s = ST_HDNG_WAIT;
          end
        end
        ST_HDNG_WAIT: begin
          if ((cnt_r == 4'd0) && mv_cmplt) begin
            state_nxt_s = ST_MV;
          end else begin
            state_nxt_s = ST_HDNG_WAIT;
          end
        end
        ST_DONE: state_nxt_s = ST_DONE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs, affinity and settle/handshake counter.
  always_comb begin
    aff_nxt_s       = aff_r;
    cnt_nxt_s       = cnt_r;
    dsrd_hdng_nxt_s = dsrd_hdng_r;
    stp_lft_nxt_s   = stp_lft_r;
    stp_rght_nxt_s  = stp_rght_r;
    strt_hdng_nxt_s = 1'b0;
    strt_mv_nxt_s   = (state_nxt_s == ST_MV);
    solved_nxt_s    = (state_nxt_s == ST_DONE);
    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = 4'd0;
        if (cmd_md) begin
          aff_nxt_s      = cmd0;
          stp_lft_nxt_s  = cmd0;
          stp_rght_nxt_s = ~cmd0;
        end else begin
          stp_lft_nxt_s  = 1'b0;
          stp_rght_nxt_s = 1'b0;
        end
      end
      ST_MV_WAIT: begin
        if (mv_cmplt) begin
          cnt_nxt_s = SETTLE_LOAD;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_SETTLE: begin
        if (cnt_r != 4'd0) begin
          cnt_nxt_s = cnt_r - 4'd1;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_DECIDE: begin
        if (cmd_md && !sol_cmplt) begin
          if (aff_open_s) begin
            dsrd_hdng_nxt_s = toward_hdng_s;
            cnt_nxt_s       = HDNG_LOAD;
          end else if (frwrd_opn) begin
            dsrd_hdng_nxt_s = dsrd_hdng_r;
          end else if (opp_open_s) begin
            dsrd_hdng_nxt_s = away_hdng_s;
            cnt_nxt_s       = HDNG_LOAD;
          end else begin
            dsrd_hdng_nxt_s = turn_rev(dsrd_hdng_r);
            cnt_nxt_s       = HDNG_LOAD;
          end
        end else begin
          dsrd_hdng_nxt_s = dsrd_hdng_r;
        end
      end
      ST_HDNG_WAIT: begin
        strt_hdng_nxt_s = cmd_md && (cnt_r == HDNG_LOAD);
        if (cnt_r != 4'd0) begin
          cnt_nxt_s = cnt_r - 4'd1;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: begin
        cnt_nxt_s = cnt_r;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aff_r       <= 1'b0;
      cnt_r       <= 4'd0;
      dsrd_hdng_r <= HDNG_N;
      strt_hdng_r <= 1'b0;
      strt_mv_r   <= 1'b0;
      stp_lft_r   <= 1'b0;
      stp_rght_r  <= 1'b0;
      solved_r    <= 1'b0;
    end else begin
      aff_r       <= aff_nxt_s;
      cnt_r       <= cnt_nxt_s;
      dsrd_hdng_r <= dsrd_hdng_nxt_s;
      strt_hdng_r <= strt_hdng_nxt_s;
      strt_mv_r   <= strt_mv_nxt_s;
      stp_lft_r   <= stp_lft_nxt_s;
      stp_rght_r  <= stp_rght_nxt_s;
      solved_r    <= solved_nxt_s;
    end
  end

  assign strt_hdng = strt_hdng_r;
  assign strt_mv   = strt_mv_r;
  assign stp_lft   = stp_lft_r;
  assign stp_rght  = stp_rght_r;
  assign dsrd_hdng = dsrd_hdng_r;
  assign solved    = solved_r;

endmodule
